timer_n: RTL and testbench
==========================

Name: timer_n

Overview:
Parametrised successor to the rAVR 8-bit systick timer.
- W-bit up-counter (8..16) on the 6-bit I/O bus, clocked by prescaler tick timer_clk.
- Adds one output-compare channel, CTC and fast-PWM modes, and a compare-match interrupt.
- Adds AVR-style atomic 16-bit access through a shared TEMP byte.
- Sits beside the prescaler and the interrupt controller; the prescaler is selected via timer_clk_sel.

Parameters:
base_addr, 6'h10, I/O address of TCNTL; block occupies base_addr..base_addr+6
W, 16, counter/OCR width, legal 8..16; MAX = 2^W-1

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
io_a  in  6  I/O address
io_we  in  1  write strobe
io_re  in  1  read strobe
io_di  in  8  write data
io_do  out  8  read data, registered
timer_clk  in  1  one-sys_clk-wide count enable from prescaler
timer_clk_sel  out  3  CS field to prescaler (0 = stopped)
timer_ov_irq  out  1  TOIE & TOV
timer_ov_irq_ack  in  1  clears TOV
timer_oc_irq  out  1  OCIE & OCF
timer_oc_irq_ack  in  1  clears OCF
pwm_out  out  1  PWM output (RAVR_TIMER_PWM_EN only)

Behaviour:
Register map (offset from base_addr):
- 0 TCNTL, 1 TCNTH, 2 OCRL, 3 OCRH.
- 4 TCCR = {3'b0, MODE[1:0], CS[2:0]}.
- 5 TIMSK = {TOIE, OCIE, 6'b0}.
- 6 TIFR = {TOV, OCF, 6'b0}.

Reset values: all registers, TEMP, io_do, flags and pwm_out = 0.

Bus reads:
- io_do is registered with 1-cycle latency; it is 0 on any cycle without a selected io_re.
- Unused bits and bits >= W read 0.

16-bit access (W>8):
- Read TCNTL/OCRL returns the low byte and latches the high bits into TEMP.
- Read TCNTH/OCRH returns TEMP.
- Write TCNTH/OCRH loads TEMP only.
- Write TCNTL/OCRL commits {TEMP, io_di} in one cycle.
- For W=8, high-byte writes are ignored and high-byte reads return 0.

Counting happens on a cycle with timer_clk=1 and CS!=0 (a "tick").

MODE=00 normal:
- count+1 wrapping MAX->0.
- TOV set on the tick where count==MAX.

MODE=01 CTC:
- On a tick with count==OCR_act, count->0; otherwise count+1.
- TOV set only when wrapping from MAX.

MODE=10 fast PWM:
- Counts 0..MAX like normal.
- OCR writes go to OCR_buf; OCR_act <= OCR_buf on the tick where count wraps to 0.
- In MODE 00 and 01, OCR_act tracks OCR_buf immediately.

MODE=11: reserved, behaves as 00.

Compare flag: OCF set on every tick where count==OCR_act (all modes), evaluated on the pre-increment value.

Priorities:
- CPU write to TCNTL on a tick cycle: write wins, no increment, no flag from that tick.
- Flag set and clear (ack, or writing 1 to the TIFR bit) in the same cycle: set wins.
- Writing 0 to a TIFR bit has no effect.
- Mode change takes effect the next cycle; count is not cleared.
- If OCR_act < count in CTC, count runs to MAX, wraps, then matches.

Optional Feature:
RAVR_TIMER_PWM_EN
- Defined: pwm_out is registered: pwm_out <= (MODE==10) & (count < OCR_act).
  - OCR_act=0 gives a constant 0.
  - OCR_act=MAX gives low only while count==MAX.
- Undefined: pwm_out port is absent; OCR_buf/OCR_act double-buffering is still present.

Decomposition:
Shared include ravr_timer_defs:
- register offsets 0..6
- MODE encodings (NORMAL=2'b00, CTC=2'b01, FPWM=2'b10)
- TIMSK/TIFR bit positions

Sub-module timer_n_core (W parameter):
- counter, compare, OCR double-buffer, TOV/OCF set pulses, pwm_out.

The top level holds the bus decode, TEMP, control registers and flag/ack logic.

Test Plan:
1. W=16, CS=1, TCNT written 0xFFFE (OCRH/TCNTH=0xFF then L=0xFE), TOIE=1, 2 ticks -> count=0x0000; TOV=1 and timer_ov_irq=1 one cycle after the second tick; ov ack -> TOV=0.
2. W=16, TCNT=0x12FF, tick coincident with a read of TCNTL then TCNTH -> reads 0xFF then 0x12 (TEMP latched, not 0x13).
3. CTC, OCR=5, TCNT=0, OCIE=1 -> sequence 0..5,0,...; OCF set at each 5->0 tick; TOV never set over 20 ticks.
4. Fast PWM, W=8, OCR=0x40, OCR written to 0x80 at count 0x10 -> duty stays 0x40 until the wrap; next period pwm_out high for 128 ticks (macro defined).
5. TCNTL write on a tick cycle with count==OCR_act, plus tov0-style write-1 on TIFR together with an overflow tick -> write value loaded, no OCF; TOV remains 1.
6. Assert sys_rst mid-count -> all outputs 0 immediately (asynchronous), CS=0, no ticks honoured until CS rewritten.

Source files
------------

// File: rtl/timer_n_pkg.sv
// timer_n shared definitions: register offsets, MODE encodings, flag/mask bit positions.
// Latency: n/a (constants only).  Backpressure: n/a.
package timer_n_pkg;

    localparam logic [2:0] OFF_TCNTL = 3'd0;
    localparam logic [2:0] OFF_TCNTH = 3'd1;
    localparam logic [2:0] OFF_OCRL  = 3'd2;
    localparam logic [2:0] OFF_OCRH  = 3'd3;
    localparam logic [2:0] OFF_TCCR  = 3'd4;
    localparam logic [2:0] OFF_TIMSK = 3'd5;
    localparam logic [2:0] OFF_TIFR  = 3'd6;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_CTC    = 2'b01,
        MODE_FPWM   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int BIT_TOIE = 7;
    localparam int BIT_OCIE = 6;
    localparam int BIT_TOV  = 7;
    localparam int BIT_OCF  = 6;

    // TIMSK and TIFR share the {bit7, bit6, 6'b0} layout.
    function automatic logic [7:0] flag_byte(input logic hi, input logic lo);
        logic [7:0] b;
        b = 8'h00;
        b[BIT_TOV] = hi;
        b[BIT_OCF] = lo;
        return b;
    endfunction

endpackage

// File: rtl/timer_n_core.sv
// timer_n counter core: W-bit counter, compare, OCR double-buffer, TOV/OCF set pulses, optional PWM (RAVR_TIMER_PWM_EN).
// Latency: count/OCR update on the edge after a tick or load; set pulses are combinational.  Backpressure: none.
module timer_n_core
    import timer_n_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  mode_e        mode,
    input  logic         tick,
    input  logic         cnt_we,
    input  logic [W-1:0] cnt_wdat,
    input  logic         ocr_we,
    input  logic [W-1:0] ocr_wdat,
    output logic [W-1:0] count,
    output logic [W-1:0] ocr_buf,
    output logic         tov_set,
    output logic         ocf_set
`ifdef RAVR_TIMER_PWM_EN
    ,
    output logic         pwm_out
`endif
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] ocr_act;
    logic [W-1:0] ocr_next;
    logic         at_max;
    logic         match;
    logic         adv;

    // A CPU load of TCNT on a tick cycle suppresses the increment and both flags.
    assign adv      = tick & ~cnt_we;
    assign at_max   = (count == MAX);
    assign match    = (count == ocr_act);
    assign tov_set  = adv & at_max;
    assign ocf_set  = adv & match;
    assign ocr_next = ocr_we ? ocr_wdat : ocr_buf;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count   <= '0;
            ocr_buf <= '0;
            ocr_act <= '0;
        end else begin
            if (cnt_we) begin
                count <= cnt_wdat;
            end else if (adv) begin
                if (mode == MODE_CTC && match)
                    count <= '0;
                else
                    count <= count + W'(1);
            end

            if (ocr_we)
                ocr_buf <= ocr_wdat;

            // Fast PWM only swaps in the buffered compare value at the wrap to 0.
            if (mode != MODE_FPWM)
                ocr_act <= ocr_next;
            else if (adv && at_max)
                ocr_act <= ocr_next;
        end
    end

`ifdef RAVR_TIMER_PWM_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            pwm_out <= 1'b0;
        else
            pwm_out <= (mode == MODE_FPWM) && (count < ocr_act);
    end
`endif

endmodule

// File: rtl/timer_n.sv
// timer_n: W-bit I/O-mapped timer with compare channel, CTC/fast-PWM, TEMP-based atomic 16-bit access; PWM via RAVR_TIMER_PWM_EN.
// Latency: io_do one cycle after io_re; flags/irqs one cycle after the tick.  Backpressure: none, every access completes in one cycle.
module timer_n
    import timer_n_pkg::*;
#(
    parameter logic [5:0] base_addr = 6'h10,
    parameter int         W         = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [5:0] io_a,
    input  logic       io_we,
    input  logic       io_re,
    input  logic [7:0] io_di,
    output logic [7:0] io_do,
    input  logic       timer_clk,
    output logic [2:0] timer_clk_sel,
    output logic       timer_ov_irq,
    input  logic       timer_ov_irq_ack,
    output logic       timer_oc_irq,
    input  logic       timer_oc_irq_ack
`ifdef RAVR_TIMER_PWM_EN
    ,
    output logic       pwm_out
`endif
);

    // Bits of TEMP at or above W are forced to 0, so W=8 never holds a high byte.
    localparam logic [15:0] MAX16 = 16'((17'd1 << W) - 17'd1);
    localparam logic [7:0]  HMASK = MAX16[15:8];

    logic [6:0]   rel;
    logic [2:0]   off;
    logic         sel;
    logic         wr;
    logic         rd;
    logic [7:0]   temp;
    logic [7:0]   rdata;
    mode_e        mode;
    logic [2:0]   cs;
    logic         toie, ocie, tov, ocf;
    logic         tick;
    logic         tov_set, ocf_set;
    logic [W-1:0] count, ocr_buf, wdat;
    logic [15:0]  cnt16, ocr16;

    assign rel  = {1'b0, io_a} - {1'b0, base_addr};
    assign off  = rel[2:0];
    assign sel  = (rel[6:3] == 4'd0) && (rel[2:0] != 3'd7);
    assign wr   = io_we & sel;
    assign rd   = io_re & sel;
    assign tick = timer_clk & (cs != 3'd0);

    assign wdat  = W'({temp, io_di});
    assign cnt16 = 16'(count);
    assign ocr16 = 16'(ocr_buf);

    timer_n_core #(.W(W)) u_core (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .mode     (mode),
        .tick     (tick),
        .cnt_we   (wr && off == OFF_TCNTL),
        .cnt_wdat (wdat),
        .ocr_we   (wr && off == OFF_OCRL),
        .ocr_wdat (wdat),
        .count    (count),
        .ocr_buf  (ocr_buf),
        .tov_set  (tov_set),
        .ocf_set  (ocf_set)
`ifdef RAVR_TIMER_PWM_EN
        ,
        .pwm_out  (pwm_out)
`endif
    );

    always_comb begin
        rdata = 8'h00;
        case (off)
            OFF_TCNTL: rdata = cnt16[7:0];
            OFF_TCNTH: rdata = temp;
            OFF_OCRL:  rdata = ocr16[7:0];
            OFF_OCRH:  rdata = temp;
            OFF_TCCR:  rdata = {3'b000, mode, cs};
            OFF_TIMSK: rdata = flag_byte(toie, ocie);
            OFF_TIFR:  rdata = flag_byte(tov, ocf);
            default:   rdata = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            io_do <= 8'h00;
            temp  <= 8'h00;
            mode  <= MODE_NORMAL;
            cs    <= 3'd0;
            toie  <= 1'b0;
            ocie  <= 1'b0;
            tov   <= 1'b0;
            ocf   <= 1'b0;
        end else begin
            io_do <= rd ? rdata : 8'h00;

            if (rd && off == OFF_TCNTL)
                temp <= cnt16[15:8];
            else if (rd && off == OFF_OCRL)
                temp <= ocr16[15:8];
            else if (wr && (off == OFF_TCNTH || off == OFF_OCRH))
                temp <= io_di & HMASK;

            if (wr && off == OFF_TCCR) begin
                mode <= mode_e'(io_di[4:3]);
                cs   <= io_di[2:0];
            end

            if (wr && off == OFF_TIMSK) begin
                toie <= io_di[BIT_TOIE];
                ocie <= io_di[BIT_OCIE];
            end

            // A set pulse overrides any clear arriving in the same cycle.
            tov <= tov_set | (tov & ~(timer_ov_irq_ack | (wr && off == OFF_TIFR && io_di[BIT_TOV])));
            ocf <= ocf_set | (ocf & ~(timer_oc_irq_ack | (wr && off == OFF_TIFR && io_di[BIT_OCF])));
        end
    end

    assign timer_clk_sel = cs;
    assign timer_ov_irq  = toie & tov;
    assign timer_oc_irq  = ocie & ocf;

endmodule

// File: tb/tb_timer_n.sv
// Scoreboard bench for timer_n: W=16 and W=8 instances share stimulus, each checked against its own behavioural model.
// Latency: n/a.  Backpressure: n/a.
module tb_timer_n;

    localparam logic [5:0] BASE = 6'h10;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [5:0] io_a = 6'h00;
    logic       io_we = 1'b0, io_re = 1'b0;
    logic [7:0] io_di = 8'h00;
    logic       timer_clk = 1'b0, ov_ack = 1'b0, oc_ack = 1'b0;
    logic [7:0] do16, do8;
    logic [2:0] sel16, sel8;
    logic       ovi16, oci16, ovi8, oci8;
`ifdef RAVR_TIMER_PWM_EN
    logic       pwm16, pwm8;
`endif

    always #5 sys_clk = ~sys_clk;

    timer_n #(.base_addr(BASE), .W(16)) dut16 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .io_a(io_a), .io_we(io_we), .io_re(io_re),
        .io_di(io_di), .io_do(do16), .timer_clk(timer_clk), .timer_clk_sel(sel16),
        .timer_ov_irq(ovi16), .timer_ov_irq_ack(ov_ack),
        .timer_oc_irq(oci16), .timer_oc_irq_ack(oc_ack)
`ifdef RAVR_TIMER_PWM_EN
        , .pwm_out(pwm16)
`endif
    );

    timer_n #(.base_addr(BASE), .W(8)) dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .io_a(io_a), .io_we(io_we), .io_re(io_re),
        .io_di(io_di), .io_do(do8), .timer_clk(timer_clk), .timer_clk_sel(sel8),
        .timer_ov_irq(ovi8), .timer_ov_irq_ack(ov_ack),
        .timer_oc_irq(oci8), .timer_oc_irq_ack(oc_ack)
`ifdef RAVR_TIMER_PWM_EN
        , .pwm_out(pwm8)
`endif
    );

    typedef struct {
        int cnt, ocr_buf, ocr_act, temp, mode, cs, toie, ocie, tov, ocf, io_do, pwm;
    } mdl_t;
    typedef struct {
        int io_do, ov, oc, sel, pwm;
    } exp_t;

    mdl_t m16, m8;
    exp_t q16[$], q8[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-level reference: one call = one sys_clk edge, computed from the register-map rules.
    function automatic mdl_t step(mdl_t m, int w, bit we, bit re, logic [5:0] a, int di,
                                  bit tclk, bit ova, bit oca);
        mdl_t n;
        int  maxv, hm, off;
        bit  sel, tick, cwr, tovs, ocfs;
        n    = m;
        maxv = (1 << w) - 1;
        hm   = (maxv >> 8) & 255;
        off  = int'(a) - int'(BASE);
        sel  = (off >= 0) && (off <= 6);
        tick = tclk && (m.cs != 0);
        cwr  = we && sel && off == 0;
        tovs = 0;
        ocfs = 0;
        n.io_do = 0;
        if (re && sel) begin
            case (off)
                0: begin n.io_do = m.cnt & 255; n.temp = (m.cnt >> 8) & 255; end
                1, 3: n.io_do = m.temp;
                2: begin n.io_do = m.ocr_buf & 255; n.temp = (m.ocr_buf >> 8) & 255; end
                4: n.io_do = m.mode * 8 + m.cs;
                5: n.io_do = m.toie * 128 + m.ocie * 64;
                default: n.io_do = m.tov * 128 + m.ocf * 64;
            endcase
        end
        n.pwm = (m.mode == 2 && m.cnt < m.ocr_act) ? 1 : 0;
        if (cwr) begin
            n.cnt = ((m.temp << 8) | di) & maxv;
        end else if (tick) begin
            tovs = (m.cnt == maxv);
            ocfs = (m.cnt == m.ocr_act);
            if (m.mode == 1 && ocfs) n.cnt = 0;
            else n.cnt = (m.cnt == maxv) ? 0 : m.cnt + 1;
        end
        if (we && sel && off == 2) n.ocr_buf = ((m.temp << 8) | di) & maxv;
        if (m.mode != 2 || (tick && !cwr && m.cnt == maxv)) n.ocr_act = n.ocr_buf;
        if (we && sel && (off == 1 || off == 3)) n.temp = di & hm;
        if (we && sel && off == 4) begin n.mode = (di >> 3) & 3; n.cs = di & 7; end
        if (we && sel && off == 5) begin n.toie = (di >> 7) & 1; n.ocie = (di >> 6) & 1; end
        n.tov = (tovs || (m.tov && !(ova || (we && sel && off == 6 && ((di >> 7) & 1))))) ? 1 : 0;
        n.ocf = (ocfs || (m.ocf && !(oca || (we && sel && off == 6 && ((di >> 6) & 1))))) ? 1 : 0;
        return n;
    endfunction

    function automatic exp_t mk(mdl_t m);
        exp_t e;
        e.io_do = m.io_do;
        e.ov    = m.toie & m.tov;
        e.oc    = m.ocie & m.ocf;
        e.sel   = m.cs;
        e.pwm   = m.pwm;
        return e;
    endfunction

    task automatic cyc(input bit we, input bit re, input logic [5:0] a, input logic [7:0] di,
                       input bit tclk, input bit ova, input bit oca);
        @(negedge sys_clk);
        io_we = we; io_re = re; io_a = a; io_di = di;
        timer_clk = tclk; ov_ack = ova; oc_ack = oca;
        m16 = step(m16, 16, we, re, a, int'(di), tclk, ova, oca);
        m8  = step(m8,  8,  we, re, a, int'(di), tclk, ova, oca);
        q16.push_back(mk(m16));
        q8.push_back(mk(m8));
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        cyc(1, 0, BASE + 6'(off), d, 0, 0, 0);
    endtask
    task automatic rd(input int off);
        cyc(0, 1, BASE + 6'(off), 8'h00, 0, 0, 0);
    endtask
    task automatic tk(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 6'h00, 8'h00, 1, 0, 0);
    endtask

    task automatic idle_inputs();
        io_we = 0; io_re = 0; io_a = 6'h00; io_di = 8'h00;
        timer_clk = 0; ov_ack = 0; oc_ack = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_do16"}, 32'(do16), 0);
        chk({tag, "_sel16"}, 32'(sel16), 0);
        chk({tag, "_ov16"}, 32'(ovi16), 0);
        chk({tag, "_oc16"}, 32'(oci16), 0);
        chk({tag, "_do8"}, 32'(do8), 0);
        chk({tag, "_ov8"}, 32'(ovi8), 0);
`ifdef RAVR_TIMER_PWM_EN
        chk({tag, "_pwm16"}, 32'(pwm16), 0);
        chk({tag, "_pwm8"}, 32'(pwm8), 0);
`endif
    endtask

    // Monitor: every edge produces one expected output set per instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("io_do16", 32'(do16), e.io_do);
                chk("ov_irq16", 32'(ovi16), e.ov);
                chk("oc_irq16", 32'(oci16), e.oc);
                chk("clk_sel16", 32'(sel16), e.sel);
`ifdef RAVR_TIMER_PWM_EN
                chk("pwm16", 32'(pwm16), e.pwm);
`endif
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("io_do8", 32'(do8), e.io_do);
                chk("ov_irq8", 32'(ovi8), e.ov);
                chk("oc_irq8", 32'(oci8), e.oc);
                chk("clk_sel8", 32'(sel8), e.sel);
`ifdef RAVR_TIMER_PWM_EN
                chk("pwm8", 32'(pwm8), e.pwm);
`endif
            end
        end
    end

    initial begin
        int hi;
        m16 = '{default: 0};
        m8  = '{default: 0};
        repeat (3) @(negedge sys_clk);
        chk_all_zero("reset");
        sys_rst = 0;

        // Overflow from 0xFFFE with TOIE, then ack.
        wr(4, 8'h01); wr(1, 8'hFF); wr(0, 8'hFE); wr(5, 8'h80);
        tk(2);
        rd(6); rd(0); rd(1);
        cyc(0, 0, 6'h00, 8'h00, 0, 1, 0);
        rd(6);

        // Read of TCNTL coincident with a tick latches the pre-increment high byte.
        wr(4, 8'h00);
        wr(1, 8'h12); wr(0, 8'hFF); wr(4, 8'h01);
        cyc(0, 1, BASE, 8'h00, 1, 0, 0);
        rd(1);

        // CTC with OCR=5.
        wr(4, 8'h09); wr(3, 8'h00); wr(2, 8'h05); wr(1, 8'h00); wr(0, 8'h00); wr(5, 8'h40);
        for (int i = 0; i < 20; i++) begin
            tk(1);
            rd(0);
            if (i % 7 == 6) cyc(0, 1, BASE + 6'd6, 8'h00, 0, 0, 1);
        end
        rd(6);

        // Fast PWM: OCR change at count 0x10 only takes effect after the wrap.
        wr(4, 8'h11); wr(3, 8'h00); wr(2, 8'h40); wr(1, 8'h00); wr(0, 8'h00);
        tk(16);
        wr(3, 8'h00); wr(2, 8'h80);
        tk(240);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tk(1);
            @(posedge sys_clk);
            #2;
`ifdef RAVR_TIMER_PWM_EN
            hi += int'(pwm8);
`endif
        end
`ifdef RAVR_TIMER_PWM_EN
        chk("pwm8_duty_period", 32'(hi), 128);
`endif

        // TCNTL write beats a matching tick; TIFR write-1 loses to an overflow tick.
        wr(4, 8'h01); wr(5, 8'hC0); wr(6, 8'hC0);
        wr(3, 8'h00); wr(2, 8'h20); wr(1, 8'h00); wr(0, 8'h20);
        cyc(1, 0, BASE, 8'h55, 1, 0, 0);
        rd(6); rd(0);
        wr(1, 8'hFF); wr(0, 8'hFF);
        cyc(1, 0, BASE + 6'd6, 8'h80, 1, 0, 0);
        rd(6);

        // Asynchronous reset mid-count.
        tk(3); rd(4);
        @(posedge sys_clk);
        #3;
        idle_inputs();
        sys_rst = 1;
        #1;
        chk_all_zero("async_rst");
        @(negedge sys_clk);
        sys_rst = 0;
        m16 = '{default: 0};
        m8  = '{default: 0};
        tk(5); rd(0); rd(4);
        wr(4, 8'h01); tk(3); rd(0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int op;
            logic [5:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 15) == 0) ? 6'($urandom) : BASE + 6'($urandom_range(0, 6));
            cyc(op < 3, op >= 3 && op < 6, a, 8'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        @(negedge sys_clk);
        idle_inputs();
        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
